// File: rtl/reg_file_wb_if.sv
// Bus bundle between the pipeline (master) and the register file (slave).
interface reg_file_wb_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 3
);
    logic              wb_en;
    logic [ADDR_W-1:0] wb_addr;
    logic [DATA_W-1:0] ans_wb;
    logic              issue_en;
    logic [ADDR_W-1:0] issue_addr;
    logic [ADDR_W-1:0] rd_addr_a;
    logic [ADDR_W-1:0] rd_addr_b;
    logic [DATA_W-1:0] rd_data_a;
    logic [DATA_W-1:0] rd_data_b;
    logic              stall;
    logic              sb_err;

    modport master (
        output wb_en, wb_addr, ans_wb, issue_en, issue_addr, rd_addr_a, rd_addr_b,
        input  rd_data_a, rd_data_b, stall, sb_err
    );

    modport slave (
        input  wb_en, wb_addr, ans_wb, issue_en, issue_addr, rd_addr_a, rd_addr_b,
        output rd_data_a, rd_data_b, stall, sb_err
    );
endinterface

// File: rtl/reg_file_wb.sv
// Write-back register file: 2 read ports with WB bypass, r0 hardwired zero,
// and a per-register pending-write scoreboard that drives decode stall.
module reg_file_wb #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 3,
    parameter int CNT_W  = 2
) (
    input  logic         clk,
    input  logic         reset,
    reg_file_wb_if.slave bus
);
    localparam int NREG = 1 << ADDR_W;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [DATA_W-1:0] regs_q [NREG];
    logic [DATA_W-1:0] regs_d [NREG];
    logic [CNT_W-1:0]  cnt_q  [NREG];
    logic [CNT_W-1:0]  cnt_d  [NREG];
    logic              sb_err_q, sb_err_d;

    logic byp_a, byp_b, pend_a, pend_b, iss_full, stall;

    always_comb begin
        byp_a = bus.wb_en && (bus.wb_addr == bus.rd_addr_a);
        byp_b = bus.wb_en && (bus.wb_addr == bus.rd_addr_b);
        // A write-back landing this cycle retires one outstanding write.
        pend_a = (bus.rd_addr_a != '0) && (cnt_q[bus.rd_addr_a] > CNT_W'(byp_a));
        pend_b = (bus.rd_addr_b != '0) && (cnt_q[bus.rd_addr_b] > CNT_W'(byp_b));
        iss_full = bus.issue_en && (bus.issue_addr != '0)
                   && (cnt_q[bus.issue_addr] == CNT_MAX)
                   && !(bus.wb_en && (bus.wb_addr == bus.issue_addr));
        stall = reset && (pend_a || pend_b || iss_full);

        bus.rd_data_a = '0;
        if (reset && (bus.rd_addr_a != '0))
            bus.rd_data_a = byp_a ? bus.ans_wb : regs_q[bus.rd_addr_a];
        bus.rd_data_b = '0;
        if (reset && (bus.rd_addr_b != '0))
            bus.rd_data_b = byp_b ? bus.ans_wb : regs_q[bus.rd_addr_b];
    end

    assign bus.stall  = stall;
    assign bus.sb_err = sb_err_q;

    always_comb begin
        logic inc, dec;
        inc      = 1'b0;
        dec      = 1'b0;
        regs_d   = regs_q;
        cnt_d    = cnt_q;
        sb_err_d = sb_err_q;

        if (bus.wb_en && (bus.wb_addr != '0))
            regs_d[bus.wb_addr] = bus.ans_wb;

        for (int r = 1; r < NREG; r++) begin
            inc = bus.issue_en && !stall && (bus.issue_addr == ADDR_W'(r));
            dec = bus.wb_en && (bus.wb_addr == ADDR_W'(r));
            if (inc && !dec) begin
                if (cnt_q[r] == CNT_MAX) sb_err_d = 1'b1;
                else                     cnt_d[r] = cnt_q[r] + 1'b1;
            end else if (dec && !inc) begin
                if (cnt_q[r] == '0) sb_err_d = 1'b1;
                else                cnt_d[r] = cnt_q[r] - 1'b1;
            end
        end

        regs_d[0] = '0;
        cnt_d[0]  = '0;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= '0;
                cnt_q[i]  <= '0;
            end
            sb_err_q <= 1'b0;
        end else begin
            regs_q   <= regs_d;
            cnt_q    <= cnt_d;
            sb_err_q <= sb_err_d;
        end
    end
endmodule

// File: tb/tb_reg_file_wb.sv
// Self-checking bench for reg_file_wb: directed vector table, then a
// randomised run scored against a small behavioural model.
module tb_reg_file_wb;
    logic clk = 1'b0;
    logic reset = 1'b0;

    always #5 clk = ~clk;

    reg_file_wb_if #(.DATA_W(16), .ADDR_W(3)) bus ();

    reg_file_wb #(.DATA_W(16), .ADDR_W(3), .CNT_W(2)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    typedef struct {
        logic        rst;
        logic        we;
        logic [2:0]  wa;
        logic [15:0] ans;
        logic        ie;
        logic [2:0]  ia;
        logic [2:0]  ra;
        logic [2:0]  rb;
        logic [15:0] ea;
        logic [15:0] eb;
        logic        es;
        logic        ee;
    } vec_t;

    typedef struct {
        int          idx;
        logic [15:0] ea;
        logic [15:0] eb;
        logic        es;
        logic        ee;
    } exp_t;

    vec_t tbl[$];
    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    logic [15:0] m_reg [8];
    int          m_cnt [8];
    logic        m_err;

    function automatic vec_t mk(bit rst, bit we, int wa, int ans, bit ie, int ia,
                                int ra, int rb, int ea, int eb, bit es, bit ee);
        vec_t v;
        v.rst = rst; v.we = we; v.wa = 3'(wa); v.ans = 16'(ans);
        v.ie = ie; v.ia = 3'(ia); v.ra = 3'(ra); v.rb = 3'(rb);
        v.ea = 16'(ea); v.eb = 16'(eb); v.es = es; v.ee = ee;
        return v;
    endfunction

    task automatic chk(input string nm, input int idx, input logic [15:0] act, input logic [15:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s vec %0d: got %h, expected %h", nm, idx, act, req);
        end
    endtask

    function automatic logic [15:0] model_rd(vec_t v, logic [2:0] a);
        if (!v.rst || a == 3'd0) return 16'h0;
        if (v.we && v.wa == a)   return v.ans;
        return m_reg[a];
    endfunction

    function automatic bit model_pend(vec_t v, logic [2:0] a);
        if (a == 3'd0 || m_cnt[a] == 0) return 1'b0;
        // Only one retirement per cycle, so cnt==1 with a matching WB is clear.
        return !(v.we && v.wa == a && m_cnt[a] == 1);
    endfunction

    // Computes the outputs for this cycle, then advances the model by one edge.
    task automatic model_step(input vec_t v, output exp_t e);
        bit st;
        e.ea = model_rd(v, v.ra);
        e.eb = model_rd(v, v.rb);
        st = v.rst && (model_pend(v, v.ra) || model_pend(v, v.rb) ||
             (v.ie && v.ia != 0 && m_cnt[v.ia] == 3 && !(v.we && v.wa == v.ia)));
        e.es = st;
        e.ee = m_err;
        if (!v.rst) begin
            for (int i = 0; i < 8; i++) begin m_reg[i] = 16'h0; m_cnt[i] = 0; end
            m_err = 1'b0;
        end else begin
            if (v.we && v.wa != 0) m_reg[v.wa] = v.ans;
            for (int r = 1; r < 8; r++) begin
                bit inc, dec;
                inc = v.ie && !st && v.ia == 3'(r);
                dec = v.we && v.wa == 3'(r);
                if (inc && !dec) begin
                    if (m_cnt[r] == 3) m_err = 1'b1; else m_cnt[r]++;
                end else if (dec && !inc) begin
                    if (m_cnt[r] == 0) m_err = 1'b1; else m_cnt[r]--;
                end
            end
        end
    endtask

    task automatic apply(input vec_t v, input exp_t e);
        exp_t got;
        @(posedge clk);
        #1;
        reset          = v.rst;
        bus.wb_en      = v.we;
        bus.wb_addr    = v.wa;
        bus.ans_wb     = v.ans;
        bus.issue_en   = v.ie;
        bus.issue_addr = v.ia;
        bus.rd_addr_a  = v.ra;
        bus.rd_addr_b  = v.rb;
        exp_q.push_back(e);
        @(negedge clk);
        got = exp_q.pop_front();
        chk("rd_data_a", got.idx, bus.rd_data_a, got.ea);
        chk("rd_data_b", got.idx, bus.rd_data_b, got.eb);
        chk("stall",     got.idx, 16'(bus.stall),  16'(got.es));
        chk("sb_err",    got.idx, 16'(bus.sb_err), 16'(got.ee));
    endtask

    initial begin
        exp_t e, me;
        vec_t v;

        for (int i = 0; i < 8; i++) begin m_reg[i] = 16'h0; m_cnt[i] = 0; end
        m_err = 1'b0;
        bus.wb_en = 0; bus.wb_addr = 0; bus.ans_wb = 0; bus.issue_en = 0;
        bus.issue_addr = 0; bus.rd_addr_a = 0; bus.rd_addr_b = 0;
        repeat (3) @(posedge clk);

        //              rst we wa ans      ie ia ra rb  ea       eb       es ee
        tbl.push_back(mk(1, 0, 0, 0,       1, 3, 0, 0, 0,       0,       0, 0));
        tbl.push_back(mk(1, 1, 3, 'h1234,  0, 0, 3, 3, 'h1234,  'h1234,  0, 0));
        tbl.push_back(mk(1, 0, 0, 0,       0, 0, 3, 0, 'h1234,  0,       0, 0));
        tbl.push_back(mk(0, 1, 3, 5,       1, 4, 3, 3, 0,       0,       0, 0));
        tbl.push_back(mk(0, 0, 0, 0,       1, 5, 3, 0, 0,       0,       0, 0));
        tbl.push_back(mk(1, 0, 0, 0,       0, 0, 3, 3, 0,       0,       0, 0));
        tbl.push_back(mk(1, 0, 0, 0,       1, 3, 0, 0, 0,       0,       0, 0));
        tbl.push_back(mk(1, 1, 3, 2,       0, 0, 3, 0, 2,       0,       0, 0));
        tbl.push_back(mk(1, 0, 0, 0,       0, 0, 3, 0, 2,       0,       0, 0));
        tbl.push_back(mk(1, 1, 0, 'hFFFF,  0, 0, 0, 0, 0,       0,       0, 0));
        tbl.push_back(mk(1, 0, 0, 0,       0, 0, 0, 3, 0,       2,       0, 0));
        tbl.push_back(mk(1, 0, 0, 0,       1, 5, 0, 0, 0,       0,       0, 0));
        tbl.push_back(mk(1, 0, 0, 0,       0, 0, 0, 5, 0,       0,       1, 0));
        tbl.push_back(mk(1, 0, 0, 0,       0, 0, 0, 5, 0,       0,       1, 0));
        tbl.push_back(mk(1, 1, 5, 3,       0, 0, 0, 5, 0,       3,       0, 0));
        tbl.push_back(mk(1, 0, 0, 0,       0, 0, 0, 5, 0,       3,       0, 0));
        tbl.push_back(mk(1, 0, 0, 0,       1, 2, 0, 0, 0,       0,       0, 0));
        tbl.push_back(mk(1, 1, 2, 7,       1, 2, 2, 0, 7,       0,       0, 0));
        tbl.push_back(mk(1, 0, 0, 0,       0, 0, 2, 0, 7,       0,       1, 0));
        tbl.push_back(mk(1, 1, 2, 9,       0, 0, 2, 0, 9,       0,       0, 0));
        tbl.push_back(mk(1, 0, 0, 0,       1, 4, 0, 0, 0,       0,       0, 0));
        tbl.push_back(mk(1, 0, 0, 0,       1, 4, 0, 0, 0,       0,       0, 0));
        tbl.push_back(mk(1, 0, 0, 0,       1, 4, 0, 0, 0,       0,       0, 0));
        tbl.push_back(mk(1, 0, 0, 0,       1, 4, 0, 0, 0,       0,       1, 0));
        tbl.push_back(mk(1, 0, 0, 0,       0, 0, 4, 0, 0,       0,       1, 0));
        tbl.push_back(mk(1, 1, 4, 'h11,    0, 0, 4, 0, 'h11,    0,       1, 0));
        tbl.push_back(mk(1, 1, 4, 'h22,    0, 0, 4, 0, 'h22,    0,       1, 0));
        tbl.push_back(mk(1, 1, 4, 'h33,    0, 0, 4, 0, 'h33,    0,       0, 0));
        tbl.push_back(mk(1, 1, 4, 'h44,    0, 0, 4, 0, 'h44,    0,       0, 0));
        tbl.push_back(mk(1, 0, 0, 0,       0, 0, 4, 0, 'h44,    0,       0, 1));
        tbl.push_back(mk(0, 0, 0, 0,       0, 0, 4, 0, 0,       0,       0, 1));
        tbl.push_back(mk(1, 0, 0, 0,       0, 0, 4, 0, 0,       0,       0, 0));
        tbl.push_back(mk(1, 0, 0, 0,       1, 6, 0, 0, 0,       0,       0, 0));
        tbl.push_back(mk(1, 0, 0, 0,       1, 7, 0, 6, 0,       0,       1, 0));
        tbl.push_back(mk(1, 0, 0, 0,       0, 0, 0, 7, 0,       0,       0, 0));
        tbl.push_back(mk(1, 1, 6, 'h66,    0, 0, 6, 0, 'h66,    0,       0, 0));

        foreach (tbl[i]) begin
            e.idx = i; e.ea = tbl[i].ea; e.eb = tbl[i].eb; e.es = tbl[i].es; e.ee = tbl[i].ee;
            model_step(tbl[i], me);
            apply(tbl[i], e);
        end

        for (int i = 0; i < 400; i++) begin
            v.rst = ($urandom_range(39) != 0);
            v.we  = ($urandom_range(9) < 4);
            v.wa  = 3'($urandom_range(7));
            v.ans = 16'($urandom);
            v.ie  = ($urandom_range(1) == 1);
            v.ia  = 3'($urandom_range(7));
            v.ra  = 3'($urandom_range(7));
            v.rb  = 3'($urandom_range(7));
            model_step(v, e);
            e.idx = 1000 + i;
            apply(v, e);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
